// File: rtl/rp_m_axi_mem_model.sv
// Behavioural AXI4 slave memory that sits downstream of the RP M_AXI master.
// Absorbs read/write bursts into a local word array. Read data comes back a
// fixed number of cycles after the AR handshake. Completed bursts are counted.
`timescale 1ns/1ps
module rp_m_axi_mem_model #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_AW     = 10,
  parameter int RD_LATENCY = 4
) (
  input  logic                    pe_clk,
  input  logic                    pe_clk_rst,
  // write address
  input  logic [ID_WIDTH-1:0]     M_AXI_awid,
  input  logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
  input  logic [7:0]              M_AXI_awlen,
  input  logic [2:0]              M_AXI_awsize,
  input  logic [1:0]              M_AXI_awburst,
  input  logic                    M_AXI_awvalid,
  output logic                    M_AXI_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   M_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
  input  logic                    M_AXI_wlast,
  input  logic                    M_AXI_wvalid,
  output logic                    M_AXI_wready,
  // write response
  output logic [ID_WIDTH-1:0]     M_AXI_bid,
  output logic [1:0]              M_AXI_bresp,
  output logic                    M_AXI_bvalid,
  input  logic                    M_AXI_bready,
  // read address
  input  logic [ID_WIDTH-1:0]     M_AXI_arid,
  input  logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
  input  logic [7:0]              M_AXI_arlen,
  input  logic [2:0]              M_AXI_arsize,
  input  logic [1:0]              M_AXI_arburst,
  input  logic                    M_AXI_arvalid,
  output logic                    M_AXI_arready,
  // read data
  output logic [ID_WIDTH-1:0]     M_AXI_rid,
  output logic [DATA_WIDTH-1:0]   M_AXI_rdata,
  output logic [1:0]              M_AXI_rresp,
  output logic                    M_AXI_rlast,
  output logic                    M_AXI_rvalid,
  input  logic                    M_AXI_rready,
  // bench visibility
  output logic [31:0]             wr_burst_cnt,
  output logic [31:0]             rd_burst_cnt
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OB    = $clog2(NB);
  localparam int DEPTH = 1 << MEM_AW;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BT_FIXED    = 2'b00;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  // Latched per-burst request state; err is resolved once at the address phase.
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [MEM_AW-1:0]   idx;
    logic [7:0]          len;
    logic [1:0]          burst;
    logic [1:0]          err;
  } burst_t;

  // Out-of-range start address wins over an unsupported burst type.
  function automatic logic [1:0] start_err(input logic [ADDR_WIDTH-1:0] a,
                                           input logic [1:0] bt);
    if ((a >> (MEM_AW + OB)) != '0) return RESP_DECERR;
    if (bt[1])                      return RESP_SLVERR;  // WRAP or reserved
    return RESP_OKAY;
  endfunction

  // INCR wraps modulo the memory depth; FIXED stays put.
  function automatic logic [MEM_AW-1:0] next_idx(input burst_t b);
    return (b.burst == BT_FIXED) ? b.idx : b.idx + 1'b1;
  endfunction

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [1:0] w_state;
  logic [1:0] r_state;
  burst_t     wb;
  burst_t     rb;
  logic [8:0] w_beat;   // saturates at 256 so overruns never alias to len
  logic [7:0] r_beat;
  logic [3:0] r_lat;

  logic                  w_hs;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] r_word;

  // Sizes and sub-word address bits carry no information in this model.
  logic unused_ok;
  assign unused_ok = ^{M_AXI_awsize, M_AXI_arsize,
                       M_AXI_awaddr[OB-1:0], M_AXI_araddr[OB-1:0]};

  assign M_AXI_awready = (w_state == W_IDLE);
  assign M_AXI_wready  = (w_state == W_DATA);
  assign M_AXI_bvalid  = (w_state == W_RESP);
  assign M_AXI_arready = (r_state == R_IDLE);

  assign w_hs   = M_AXI_wvalid && M_AXI_wready;
  assign w_we   = w_hs && (wb.err == RESP_OKAY) && (w_beat <= {1'b0, wb.len});
  // Errored bursts return zeros; the array read is the pre-write value.
  assign r_word = (rb.err == RESP_OKAY) ? mem[rb.idx] : '0;

  // Byte-strobed array write; never reset so contents survive pe_clk_rst.
  always_ff @(posedge pe_clk) begin
    if (w_we) begin
      for (int b = 0; b < NB; b++) begin
        if (M_AXI_wstrb[b]) mem[wb.idx][b*8 +: 8] <= M_AXI_wdata[b*8 +: 8];
      end
    end
  end

  // Write channel FSM: address, data beats, response.
  always_ff @(posedge pe_clk or posedge pe_clk_rst) begin
    if (pe_clk_rst) begin
      w_state      <= W_IDLE;
      wb           <= '0;
      w_beat       <= '0;
      M_AXI_bid    <= '0;
      M_AXI_bresp  <= RESP_OKAY;
      wr_burst_cnt <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (M_AXI_awvalid) begin
            wb.id    <= M_AXI_awid;
            wb.idx   <= M_AXI_awaddr[MEM_AW+OB-1:OB];
            wb.len   <= M_AXI_awlen;
            wb.burst <= M_AXI_awburst;
            wb.err   <= start_err(M_AXI_awaddr, M_AXI_awburst);
            w_beat   <= '0;
            w_state  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            wb.idx <= next_idx(wb);
            if (w_beat != 9'h100) w_beat <= w_beat + 9'd1;
            if (M_AXI_wlast) begin
              // Early or late wlast is a protocol slip; keep any address error.
              M_AXI_bid   <= wb.id;
              M_AXI_bresp <= (wb.err != RESP_OKAY)       ? wb.err    :
                             (w_beat == {1'b0, wb.len})  ? RESP_OKAY : RESP_SLVERR;
              w_state     <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (M_AXI_bready) begin
            if (wr_burst_cnt != 32'hFFFF_FFFF) wr_burst_cnt <= wr_burst_cnt + 32'd1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM: address, fixed latency wait, data beats at up to 1/cycle.
  always_ff @(posedge pe_clk or posedge pe_clk_rst) begin
    if (pe_clk_rst) begin
      r_state      <= R_IDLE;
      rb           <= '0;
      r_beat       <= '0;
      r_lat        <= '0;
      M_AXI_rid    <= '0;
      M_AXI_rdata  <= '0;
      M_AXI_rresp  <= RESP_OKAY;
      M_AXI_rlast  <= 1'b0;
      M_AXI_rvalid <= 1'b0;
      rd_burst_cnt <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (M_AXI_arvalid) begin
            rb.id     <= M_AXI_arid;
            rb.idx    <= M_AXI_araddr[MEM_AW+OB-1:OB];
            rb.len    <= M_AXI_arlen;
            rb.burst  <= M_AXI_arburst;
            rb.err    <= start_err(M_AXI_araddr, M_AXI_arburst);
            M_AXI_rid <= M_AXI_arid;
            r_lat     <= 4'(RD_LATENCY - 1);
            r_state   <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_lat == 4'd0) begin
            M_AXI_rdata  <= r_word;
            M_AXI_rresp  <= rb.err;
            M_AXI_rlast  <= (rb.len == 8'd0);
            M_AXI_rvalid <= 1'b1;
            r_beat       <= 8'd0;
            rb.idx       <= next_idx(rb);
            r_state      <= R_DATA;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        R_DATA: begin
          if (M_AXI_rready) begin
            if (M_AXI_rlast) begin
              M_AXI_rvalid <= 1'b0;
              M_AXI_rlast  <= 1'b0;
              if (rd_burst_cnt != 32'hFFFF_FFFF) rd_burst_cnt <= rd_burst_cnt + 32'd1;
              r_state      <= R_IDLE;
            end else begin
              // Next beat is loaded on the handshake edge for back-to-back flow.
              M_AXI_rdata <= r_word;
              M_AXI_rlast <= ((r_beat + 8'd1) == rb.len);
              r_beat      <= r_beat + 8'd1;
              rb.idx      <= next_idx(rb);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rp_m_axi_mem_model.sv
// Directed bench for rp_m_axi_mem_model: each task drives one scenario and
// compares DUT outputs against hand-computed values.
`timescale 1ns/1ps
module tb_rp_m_axi_mem_model;

  logic         pe_clk = 1'b0;
  logic         pe_clk_rst;
  logic [3:0]   M_AXI_awid;
  logic [63:0]  M_AXI_awaddr;
  logic [7:0]   M_AXI_awlen;
  logic [2:0]   M_AXI_awsize;
  logic [1:0]   M_AXI_awburst;
  logic         M_AXI_awvalid;
  logic         M_AXI_awready;
  logic [511:0] M_AXI_wdata;
  logic [63:0]  M_AXI_wstrb;
  logic         M_AXI_wlast;
  logic         M_AXI_wvalid;
  logic         M_AXI_wready;
  logic [3:0]   M_AXI_bid;
  logic [1:0]   M_AXI_bresp;
  logic         M_AXI_bvalid;
  logic         M_AXI_bready;
  logic [3:0]   M_AXI_arid;
  logic [63:0]  M_AXI_araddr;
  logic [7:0]   M_AXI_arlen;
  logic [2:0]   M_AXI_arsize;
  logic [1:0]   M_AXI_arburst;
  logic         M_AXI_arvalid;
  logic         M_AXI_arready;
  logic [3:0]   M_AXI_rid;
  logic [511:0] M_AXI_rdata;
  logic [1:0]   M_AXI_rresp;
  logic         M_AXI_rlast;
  logic         M_AXI_rvalid;
  logic         M_AXI_rready;
  logic [31:0]  wr_burst_cnt;
  logic [31:0]  rd_burst_cnt;

  int checks = 0;
  int failures = 0;
  int exp_wr = 0;
  int exp_rd = 0;

  logic [511:0] rd_data[$];
  logic [1:0]   rd_resp[$];
  logic         rd_last[$];

  always #5 pe_clk = ~pe_clk;

  rp_m_axi_mem_model dut (
    .pe_clk(pe_clk), .pe_clk_rst(pe_clk_rst),
    .M_AXI_awid(M_AXI_awid), .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awlen(M_AXI_awlen),
    .M_AXI_awsize(M_AXI_awsize), .M_AXI_awburst(M_AXI_awburst),
    .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
    .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb), .M_AXI_wlast(M_AXI_wlast),
    .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
    .M_AXI_bid(M_AXI_bid), .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid),
    .M_AXI_bready(M_AXI_bready),
    .M_AXI_arid(M_AXI_arid), .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen),
    .M_AXI_arsize(M_AXI_arsize), .M_AXI_arburst(M_AXI_arburst),
    .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
    .M_AXI_rid(M_AXI_rid), .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
    .M_AXI_rlast(M_AXI_rlast), .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready),
    .wr_burst_cnt(wr_burst_cnt), .rd_burst_cnt(rd_burst_cnt)
  );

  function automatic logic [511:0] pat(input logic [31:0] s);
    return {16{s}};
  endfunction

  task automatic tick();
    @(posedge pe_clk); #1;
  endtask

  // Full write burst: AW, nbeats of W (wlast on the final one), then B.
  task automatic do_write(input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] id,
                          input logic [31:0] seed, input logic [63:0] strb,
                          input int nbeats, output logic [1:0] resp,
                          output logic [3:0] bid);
    int n;
    bit to;
    to = 0;
    M_AXI_awaddr = addr; M_AXI_awlen = len; M_AXI_awburst = burst;
    M_AXI_awid = id; M_AXI_awsize = 3'd6; M_AXI_awvalid = 1'b1;
    n = 0;
    while (!M_AXI_awready && n < 50) begin tick(); n++; end
    if (n >= 50) to = 1;
    tick();
    M_AXI_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      M_AXI_wdata = pat(seed + 32'(i)); M_AXI_wstrb = strb;
      M_AXI_wlast = (i == nbeats - 1); M_AXI_wvalid = 1'b1;
      n = 0;
      while (!M_AXI_wready && n < 50) begin tick(); n++; end
      if (n >= 50) to = 1;
      tick();
    end
    M_AXI_wvalid = 1'b0; M_AXI_wlast = 1'b0; M_AXI_bready = 1'b1;
    n = 0;
    while (!M_AXI_bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) to = 1;
    resp = M_AXI_bresp; bid = M_AXI_bid;
    tick();
    M_AXI_bready = 1'b0;
    checks++;
    if (to) begin failures++; $display("FAIL write_timeout addr=%h got=timeout want=complete", addr); end
  endtask

  // Full read burst; beats land in rd_* queues. toggle=1 drops rready every
  // other cycle and checks that a stalled beat is held unchanged.
  task automatic do_read(input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [3:0] id,
                         input bit toggle, output int lat);
    int n;
    bit held, done, to;
    logic [511:0] hd; logic hl; logic [1:0] hr;
    rd_data.delete(); rd_resp.delete(); rd_last.delete();
    to = 0;
    M_AXI_araddr = addr; M_AXI_arlen = len; M_AXI_arburst = burst;
    M_AXI_arid = id; M_AXI_arsize = 3'd6; M_AXI_arvalid = 1'b1;
    n = 0;
    while (!M_AXI_arready && n < 50) begin tick(); n++; end
    if (n >= 50) to = 1;
    tick();
    M_AXI_arvalid = 1'b0;
    lat = 0;
    while (!M_AXI_rvalid && lat < 50) begin tick(); lat++; end
    held = 0; done = 0; n = 0; hd = '0; hl = 0; hr = '0;
    while (!done && n < 300) begin
      if (held) begin
        checks++;
        if (M_AXI_rvalid !== 1'b1 || M_AXI_rdata !== hd || M_AXI_rlast !== hl || M_AXI_rresp !== hr) begin
          failures++;
          $display("FAIL r_hold got=%b/%b/%h want=1/%b/%h", M_AXI_rvalid, M_AXI_rlast, M_AXI_rdata[31:0], hl, hd[31:0]);
        end
      end
      M_AXI_rready = toggle ? (n % 2 == 0) : 1'b1;
      held = 0;
      if (M_AXI_rvalid) begin
        if (M_AXI_rready) begin
          rd_data.push_back(M_AXI_rdata); rd_resp.push_back(M_AXI_rresp);
          rd_last.push_back(M_AXI_rlast);
          checks++;
          if (M_AXI_rid !== id) begin failures++; $display("FAIL rid got=%h want=%h", M_AXI_rid, id); end
          if (M_AXI_rlast) done = 1;
        end else begin
          held = 1; hd = M_AXI_rdata; hl = M_AXI_rlast; hr = M_AXI_rresp;
        end
      end
      tick(); n++;
    end
    M_AXI_rready = 1'b0;
    checks++;
    if (to || !done) begin failures++; $display("FAIL read_timeout addr=%h got=timeout want=complete", addr); end
  endtask

  task automatic test_reset();
    pe_clk_rst = 1'b1;
    M_AXI_awvalid = 0; M_AXI_wvalid = 0; M_AXI_wlast = 0; M_AXI_bready = 0;
    M_AXI_arvalid = 0; M_AXI_rready = 0;
    M_AXI_awid = '0; M_AXI_awaddr = '0; M_AXI_awlen = '0; M_AXI_awsize = '0; M_AXI_awburst = '0;
    M_AXI_wdata = '0; M_AXI_wstrb = '0;
    M_AXI_arid = '0; M_AXI_araddr = '0; M_AXI_arlen = '0; M_AXI_arsize = '0; M_AXI_arburst = '0;
    repeat (3) tick();
    checks++;
    if (M_AXI_awready !== 1 || M_AXI_arready !== 1 || M_AXI_wready !== 0 || M_AXI_bvalid !== 0 ||
        M_AXI_rvalid !== 0 || M_AXI_rlast !== 0) begin
      failures++;
      $display("FAIL reset_handshake got=aw%b ar%b w%b b%b r%b l%b want=aw1 ar1 w0 b0 r0 l0",
               M_AXI_awready, M_AXI_arready, M_AXI_wready, M_AXI_bvalid, M_AXI_rvalid, M_AXI_rlast);
    end
    checks++;
    if (M_AXI_bresp !== 0 || M_AXI_rresp !== 0 || M_AXI_bid !== 0 || M_AXI_rid !== 0 || M_AXI_rdata !== '0) begin
      failures++;
      $display("FAIL reset_fields got=%h/%h/%h/%h/%h want=0", M_AXI_bresp, M_AXI_rresp, M_AXI_bid, M_AXI_rid, M_AXI_rdata[31:0]);
    end
    checks++;
    if (wr_burst_cnt !== 0 || rd_burst_cnt !== 0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d want=0/0", wr_burst_cnt, rd_burst_cnt);
    end
    pe_clk_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [1:0] resp; logic [3:0] bid; int lat;
    do_write(64'h40, 8'd0, 2'b01, 4'd3, 32'hA5A5A5A5, '1, 1, resp, bid); exp_wr++;
    checks++;
    if (resp !== 2'b00 || bid !== 4'd3) begin failures++; $display("FAIL single_bresp got=%b/%h want=00/3", resp, bid); end
    do_read(64'h40, 8'd0, 2'b01, 4'd6, 1'b0, lat); exp_rd++;
    checks++;
    if (lat != 4) begin failures++; $display("FAIL single_latency got=%0d want=4", lat); end
    checks++;
    if (rd_data.size() != 1 || rd_data[0] !== pat(32'hA5A5A5A5) || rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00) begin
      failures++; $display("FAIL single_rdata got_beats=%0d want=1 beat of a5 with rlast", rd_data.size());
    end
    checks++;
    if (wr_burst_cnt !== 32'(exp_wr) || rd_burst_cnt !== 32'(exp_rd)) begin
      failures++; $display("FAIL single_counters got=%0d/%0d want=%0d/%0d", wr_burst_cnt, rd_burst_cnt, exp_wr, exp_rd);
    end
  endtask

  task automatic test_incr_backpressure();
    logic [1:0] resp; logic [3:0] bid; int lat;
    do_write(64'h0, 8'd7, 2'b01, 4'd1, 32'h1000, '1, 8, resp, bid); exp_wr++;
    checks++;
    if (resp !== 2'b00) begin failures++; $display("FAIL incr_bresp got=%b want=00", resp); end
    do_read(64'h0, 8'd7, 2'b01, 4'd2, 1'b1, lat); exp_rd++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= rd_data.size() || rd_data[i] !== pat(32'(32'h1000 + i)) || rd_last[i] !== (i == 7)) begin
        failures++; $display("FAIL incr_beat%0d got_beats=%0d want=%h", i, rd_data.size(), 32'h1000 + i);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [3:0] bid; int lat;
    logic [511:0] exp;
    exp = {{60{8'hFF}}, {4{8'h00}}};
    do_write(64'hC0, 8'd0, 2'b01, 4'd0, 32'hFFFFFFFF, '1, 1, resp, bid); exp_wr++;
    do_write(64'hC0, 8'd0, 2'b01, 4'd0, 32'h00000000, 64'h0F, 1, resp, bid); exp_wr++;
    do_read(64'hC0, 8'd0, 2'b01, 4'd0, 1'b0, lat); exp_rd++;
    checks++;
    if (rd_data.size() != 1 || rd_data[0] !== exp) begin
      failures++; $display("FAIL strobe_rdata got=%h want=%h", rd_data.size() > 0 ? rd_data[0][63:0] : 64'hx, exp[63:0]);
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp; logic [3:0] bid; int lat;
    // out-of-range write aliasing word 2 must leave it untouched
    do_write(64'h10080, 8'd0, 2'b01, 4'd4, 32'hDEADBEEF, '1, 1, resp, bid); exp_wr++;
    checks++;
    if (resp !== 2'b11) begin failures++; $display("FAIL decerr_bresp got=%b want=11", resp); end
    do_read(64'h80, 8'd0, 2'b01, 4'd0, 1'b0, lat); exp_rd++;
    checks++;
    if (rd_data.size() != 1 || rd_data[0] !== pat(32'h1002)) begin
      failures++; $display("FAIL decerr_mem got_beats=%0d want=word 00001002", rd_data.size());
    end
    // WRAP read: four zero beats flagged SLVERR
    do_read(64'h0, 8'd3, 2'b10, 4'd7, 1'b0, lat); exp_rd++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rd_data.size() || rd_data[i] !== '0 || rd_resp[i] !== 2'b10 || rd_last[i] !== (i == 3)) begin
        failures++; $display("FAIL wrap_read_beat%0d got_beats=%0d want=0 slverr", i, rd_data.size());
      end
    end
    // early wlast
    do_write(64'h400, 8'd3, 2'b01, 4'd5, 32'h6000, '1, 2, resp, bid); exp_wr++;
    checks++;
    if (resp !== 2'b10) begin failures++; $display("FAIL early_wlast_bresp got=%b want=10", resp); end
    // overrun on a FIXED burst: extra beats discarded
    do_write(64'h440, 8'd0, 2'b00, 4'd5, 32'h7000, '1, 3, resp, bid); exp_wr++;
    checks++;
    if (resp !== 2'b10) begin failures++; $display("FAIL overrun_bresp got=%b want=10", resp); end
    do_read(64'h440, 8'd0, 2'b00, 4'd0, 1'b0, lat); exp_rd++;
    checks++;
    if (rd_data.size() != 1 || rd_data[0] !== pat(32'h7000)) begin
      failures++; $display("FAIL overrun_mem got_beats=%0d want=word 00007000", rd_data.size());
    end
  endtask

  task automatic test_wraparound();
    logic [1:0] resp; logic [3:0] bid; int lat;
    do_write(64'hFFC0, 8'd1, 2'b01, 4'd2, 32'h5000, '1, 2, resp, bid); exp_wr++;
    checks++;
    if (resp !== 2'b00) begin failures++; $display("FAIL wrap_bresp got=%b want=00", resp); end
    do_read(64'hFFC0, 8'd1, 2'b01, 4'd2, 1'b0, lat); exp_rd++;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= rd_data.size() || rd_data[i] !== pat(32'(32'h5000 + i)) || rd_resp[i] !== 2'b00) begin
        failures++; $display("FAIL wraparound_beat%0d got_beats=%0d want=%h", i, rd_data.size(), 32'h5000 + i);
      end
    end
    checks++;
    if (wr_burst_cnt !== 32'(exp_wr) || rd_burst_cnt !== 32'(exp_rd)) begin
      failures++; $display("FAIL mid_counters got=%0d/%0d want=%0d/%0d", wr_burst_cnt, rd_burst_cnt, exp_wr, exp_rd);
    end
  endtask

  task automatic test_concurrent_reset();
    logic [1:0] resp, resp2; logic [3:0] bid; int lat, n;
    do_write(64'h3200, 8'd15, 2'b01, 4'd1, 32'h2000, '1, 16, resp, bid); exp_wr++;
    fork
      do_write(64'h1900, 8'd15, 2'b01, 4'd1, 32'h3000, '1, 16, resp2, bid);
      do_read(64'h3200, 8'd15, 2'b01, 4'd2, 1'b0, lat);
    join
    exp_wr++; exp_rd++;
    checks++;
    if (resp !== 2'b00 || resp2 !== 2'b00) begin failures++; $display("FAIL conc_bresp got=%b/%b want=00/00", resp, resp2); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= rd_data.size() || rd_data[i] !== pat(32'(32'h2000 + i)) || rd_last[i] !== (i == 15)) begin
        failures++; $display("FAIL conc_beat%0d got_beats=%0d want=%h", i, rd_data.size(), 32'h2000 + i);
      end
    end
    checks++;
    if (wr_burst_cnt !== 32'(exp_wr) || rd_burst_cnt !== 32'(exp_rd)) begin
      failures++; $display("FAIL conc_counters got=%0d/%0d want=%0d/%0d", wr_burst_cnt, rd_burst_cnt, exp_wr, exp_rd);
    end
    // start a read and reset it after three beats
    M_AXI_araddr = 64'h1900; M_AXI_arlen = 8'd15; M_AXI_arburst = 2'b01;
    M_AXI_arid = 4'd5; M_AXI_arvalid = 1'b1; M_AXI_rready = 1'b1;
    n = 0;
    while (!M_AXI_arready && n < 50) begin tick(); n++; end
    tick();
    M_AXI_arvalid = 1'b0;
    n = 0;
    while (!M_AXI_rvalid && n < 50) begin tick(); n++; end
    repeat (3) tick();
    checks++;
    if (M_AXI_rvalid !== 1'b1) begin failures++; $display("FAIL rst_pre_rvalid got=%b want=1", M_AXI_rvalid); end
    pe_clk_rst = 1'b1;
    #1;
    checks++;
    if (M_AXI_rvalid !== 1'b0 || M_AXI_rlast !== 1'b0) begin
      failures++; $display("FAIL rst_async got=rvalid %b rlast %b want=0 0", M_AXI_rvalid, M_AXI_rlast);
    end
    M_AXI_rready = 1'b0;
    tick();
    checks++;
    if (wr_burst_cnt !== 0 || rd_burst_cnt !== 0) begin
      failures++; $display("FAIL rst_counters got=%0d/%0d want=0/0", wr_burst_cnt, rd_burst_cnt);
    end
    pe_clk_rst = 1'b0;
    exp_wr = 0; exp_rd = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (M_AXI_arready !== 1'b1 || M_AXI_rvalid !== 1'b0 || M_AXI_rlast !== 1'b0 || M_AXI_bvalid !== 1'b0) begin
        failures++; $display("FAIL rst_release c%0d got=ar%b r%b l%b b%b want=ar1 r0 l0 b0",
                             c, M_AXI_arready, M_AXI_rvalid, M_AXI_rlast, M_AXI_bvalid);
      end
    end
    do_read(64'h1900, 8'd15, 2'b01, 4'd3, 1'b1, lat); exp_rd++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= rd_data.size() || rd_data[i] !== pat(32'(32'h3000 + i)) || rd_last[i] !== (i == 15)) begin
        failures++; $display("FAIL post_rst_beat%0d got_beats=%0d want=%h", i, rd_data.size(), 32'h3000 + i);
      end
    end
    checks++;
    if (wr_burst_cnt !== 32'(exp_wr) || rd_burst_cnt !== 32'(exp_rd)) begin
      failures++; $display("FAIL post_rst_counters got=%0d/%0d want=%0d/%0d", wr_burst_cnt, rd_burst_cnt, exp_wr, exp_rd);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_backpressure();
    test_strobe();
    test_errors();
    test_wraparound();
    test_concurrent_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rp_m_axi_mem_model.md
Name: rp_m_axi_mem_model

Overview:
- Behavioural AXI4 slave memory that sits directly downstream of the RP's M_AXI master port in the RP simulation top.
- Replaces the M_AXI tie-off whenever RP_AXI_MASTER is defined.
- Absorbs the RP's read and write bursts into a local word array with configurable read latency.
- Provides completed-burst counters for the bench.

Parameters:
- DATA_WIDTH, 512, data bus width in bits; power of two, at least 32.
- ADDR_WIDTH, 64, AXI address width.
- ID_WIDTH, 4, AXI ID width.
- MEM_AW, 10, log2 of memory depth in DATA_WIDTH-bit words.
- RD_LATENCY, 4, cycles from AR handshake to first rvalid; range 1..15.

Ports:
- pe_clk  in  1  clock, all logic on rising edge.
- pe_clk_rst  in  1  asynchronous, active-high reset.
- M_AXI_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address channel.
- M_AXI_awvalid  in  1; M_AXI_awready  out  1.
- M_AXI_wdata/wstrb/wlast/wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- M_AXI_wready  out  1.
- M_AXI_bid/bresp/bvalid  out  ID_WIDTH/2/1; M_AXI_bready  in  1.
- M_AXI_arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address channel.
- M_AXI_arvalid  in  1; M_AXI_arready  out  1.
- M_AXI_rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1; M_AXI_rready  in  1.
- wr_burst_cnt  out  32  completed write bursts (B handshakes), saturating.
- rd_burst_cnt  out  32  completed read bursts (rlast handshakes), saturating.

Behaviour:
- Reset (async assert, sync release):
  - awready=1, arready=1; wready, bvalid, rvalid, rlast=0.
  - bresp, rresp, bid, rid, rdata=0.
  - Both counters 0; both FSMs idle.
  - Memory contents are NOT cleared.
- Reset mid-burst: the burst is abandoned, no response is issued, and beats already written remain in memory.
- Word index = awaddr/araddr[MEM_AW+OB-1:OB], where OB=log2(DATA_WIDTH/8). Low OB address bits are ignored (aligned-access model); awsize/arsize are ignored (full-width beats).
- Range check: any address bit at or above MEM_AW+OB nonzero -> DECERR (2'b11). Checked once per burst on the start address.
- Burst types:
  - INCR (01): index +1 per beat; wraps modulo 2^MEM_AW and stays OKAY.
  - FIXED (00): index constant.
  - WRAP (10) and reserved (11): SLVERR (2'b10); the burst is still fully accepted/returned, with no writes and rdata=0.
- Write FSM states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1. On the AW handshake, latch id, index, len, burst and error; go to W_DATA; awready drops the next cycle.
  - W_DATA: wready=1. Each W handshake writes bytes where wstrb=1, unless the burst is in error. Beat counter increments.
  - Leave W_DATA on the handshake with wlast=1, to W_RESP.
  - wlast early (beat count < len): terminate the burst, bresp=SLVERR unless DECERR is already latched.
  - Count exceeds len without wlast: further beats are accepted and discarded until wlast; bresp=SLVERR.
  - W_RESP: bvalid=1 with the latched bid and bresp, held stable until bready. The handshake increments wr_burst_cnt and returns to W_IDLE.
  - Minimum turnaround: one idle cycle with awready=1 between bursts.
- Read FSM states R_IDLE, R_WAIT, R_DATA:
  - R_IDLE: arready=1. On the AR handshake, latch fields and load the latency counter with RD_LATENCY-1; go to R_WAIT.
  - R_WAIT: decrement; when the counter reaches 0, load beat 0 into the rdata register and go to R_DATA. The first rvalid is asserted exactly RD_LATENCY cycles after the AR handshake cycle.
  - R_DATA: rvalid=1. rid/rdata/rresp/rlast are held stable while rready=0.
  - On an R handshake with rlast=0: load the next beat the same cycle, so back-to-back beats run at 1 per cycle.
  - rlast=1 on beat len. Its handshake increments rd_burst_cnt and returns to R_IDLE.
- Read and write channels are fully independent and may be active simultaneously.
- Same-word write and read-register load in one cycle: the read returns the old data (read-before-write). Writes to a beat already held in rdata do not modify the held value.
- Counters saturate at 32'hFFFFFFFF.

Test Plan:
- Single write then read: AW addr 0x40, len 0, INCR, wstrb all 1, data A5 pattern, then AR same address -> bresp OKAY; rdata equals pattern; rvalid exactly 4 cycles after AR; rlast=1; both counters =1.
- INCR burst with backpressure: write len 7 at 0x0 with incrementing words, read len 7 with rready toggling 1/0 -> eight beats in order; each beat held stable while rready=0; rlast only on beat 7.
- Partial strobe: write 0xFF..FF to word 3, then write 0 with wstrb=0x0F -> readback has low 4 bytes 0, remaining bytes FF.
- Errors:
  - awaddr bit 16 set (MEM_AW=10, OB=6) -> bresp DECERR; memory unchanged.
  - arburst WRAP -> four beats of rresp SLVERR, rdata 0.
  - wlast on beat 1 of a len-3 burst -> bresp SLVERR.
- Wrap-around: INCR write len 1 at the last word (index 1023) -> second beat lands at index 0; resp OKAY.
- Concurrency and reset: overlapping len-15 read and write to disjoint regions, then pe_clk_rst asserted mid-read burst -> both bursts complete correctly when run to completion. On the reset: rvalid=0 immediately (async); arready=1 after release; no stray rlast; counters 0; previously written data still readable.
